// File: rtl/sarray_drain.sv
// sarray_drain: drains result rows from the bottom edge of a systolic array
// into a small output FIFO. The store unit reads the rows from that FIFO with
// a valid/ready handshake. A tile-completion FSM issues a single-cycle
// post_storec_valid_o once the tile's last row has been handed to the store
// unit.
//
// Parameters:
//   DEPTH    - number of FIFO entries (power of two, >= 2)
//   AFULL_TH - occupancy at or above which almost_full_o asserts
//
// Ports:
//   clk, rst            - clock (rising edge) and synchronous active-high reset
//   cfg_last_cnt_i      - row index of the tile's final row, latched on tile start
//   bot_i_valid_i       - incoming result row valid
//   bot_i_cnt_i         - incoming row index
//   bot_i_data_i        - incoming row, 64 lanes x 32 bit
//   st_valid_o          - head row available (0 means the FIFO is empty)
//   st_ready_i          - store unit accepts the head row
//   st_cnt_o            - head row index
//   st_data_o           - head row data (don't-care while st_valid_o=0)
//   st_last_o           - head row is the last row of its tile
//   post_storec_valid_o - one-cycle pulse when a tile has been fully stored
//   almost_full_o       - occupancy >= AFULL_TH
//   overflow_o          - sticky: a row was dropped on a full FIFO
//   seq_err_o           - sticky: a row arrived with an unexpected index
//
// Build option:
//   SARRAY_DRAIN_RELU_EN - clamp negative signed 32-bit lanes to 0 on write

module sarray_drain #(
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    cfg_last_cnt_i,
  input  logic          bot_i_valid_i,
  input  logic [5:0]    bot_i_cnt_i,
  input  logic [2047:0] bot_i_data_i,
  output logic          st_valid_o,
  input  logic          st_ready_i,
  output logic [5:0]    st_cnt_o,
  output logic [2047:0] st_data_o,
  output logic          st_last_o,
  output logic          post_storec_valid_o,
  output logic          almost_full_o,
  output logic          overflow_o,
  output logic          seq_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic [5:0]    last_cnt_q;
  logic [5:0]    exp_cnt;
  logic          overflow_q, seq_err_q;

  logic [2047:0] mem_data [DEPTH];
  logic [5:0]    mem_cnt  [DEPTH];
  logic          mem_last [DEPTH];

  logic          full, empty, pop, push, in_last, head_last;
  logic [5:0]    last_cnt_eff;
  logic [2047:0] wr_data;

`ifdef SARRAY_DRAIN_RELU_EN
  function automatic logic [2047:0] relu(input logic [2047:0] d);
    logic [2047:0] r;
    r = d;
    for (int unsigned i = 0; i < 64; i++) begin
      if (d[i*32 + 31]) r[i*32 +: 32] = '0;
    end
    return r;
  endfunction
  assign wr_data = relu(bot_i_data_i);
`else
  assign wr_data = bot_i_data_i;
`endif

  assign full      = (occ == CW'(DEPTH));
  assign empty     = (occ == '0);
  assign pop       = !empty && st_ready_i;
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign push      = bot_i_valid_i && (!full || pop);
  // In IDLE the configuration is not latched yet, so the first row of a
  // tile compares against the live cfg input.
  assign last_cnt_eff = (state == IDLE) ? cfg_last_cnt_i : last_cnt_q;
  assign in_last   = (bot_i_cnt_i == last_cnt_eff);
  assign head_last = mem_last[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = in_last ? FLUSH : COLLECT;
      COLLECT: if (push && in_last) state_nxt = FLUSH;
      FLUSH:   if (pop && head_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      last_cnt_q <= '0;
      exp_cnt    <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (state == IDLE && push) last_cnt_q <= cfg_last_cnt_i;
      // Expected index restarts after the last row, so rows arriving in
      // FLUSH/DONE are checked as the start of the next tile.
      if (push) begin
        exp_cnt <= in_last ? '0 : exp_cnt + 6'd1;
        if (bot_i_cnt_i != exp_cnt) seq_err_q <= 1'b1;
      end
      if (bot_i_valid_i && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Storage array carries no reset; validity is tracked by occ alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= wr_data;
      mem_cnt[wr_ptr]  <= bot_i_cnt_i;
      mem_last[wr_ptr] <= in_last;
    end
  end

  assign st_valid_o          = !rst && !empty;
  assign st_cnt_o            = st_valid_o ? mem_cnt[rd_ptr] : '0;
  assign st_last_o           = st_valid_o && head_last;
  assign st_data_o           = mem_data[rd_ptr];
  assign post_storec_valid_o = !rst && (state == DONE);
  assign almost_full_o       = !rst && (int'(occ) >= AFULL_TH);
  assign overflow_o          = !rst && overflow_q;
  assign seq_err_o           = !rst && seq_err_q;

endmodule

// File: doc/sarray_drain.md
SARRAY_DRAIN -- requirements
Module: sarray_drain

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of output FIFO entries; it SHALL be a power of two, minimum 2.
REQ-002 The block SHALL have parameter AFULL_TH, default 3, giving the occupancy at or above which almost_full_o asserts.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port cfg_last_cnt_i  input  6  row count of the final tile row; sampled when the FSM leaves IDLE.
REQ-006 The block SHALL have port bot_i_valid_i  input  1  result row valid from the systolic array bottom edge.
REQ-007 The block SHALL have port bot_i_cnt_i  input  6  row index of the incoming result row.
REQ-008 The block SHALL have port bot_i_data_i  input  2048  result row, 64 lanes of 32-bit.
REQ-009 The block SHALL have port st_valid_o  output  1  row available to the store unit.
REQ-010 The block SHALL have port st_ready_i  input  1  store unit accepts the row.
REQ-011 The block SHALL have port st_cnt_o  output  6  row index of the head row.
REQ-012 The block SHALL have port st_data_o  output  2048  head row data.
REQ-013 The block SHALL have port st_last_o  output  1  head row is the tile's last row.
REQ-014 The block SHALL have port post_storec_valid_o  output  1  single-cycle tile-stored pulse back to the array.
REQ-015 The block SHALL have port almost_full_o  output  1  occupancy >= AFULL_TH.
REQ-016 The block SHALL have port overflow_o  output  1  sticky: a row was dropped.
REQ-017 The block SHALL have port seq_err_o  output  1  sticky: a row arrived out of order.

Function
REQ-018 The block SHALL write the row on every cycle with bot_i_valid_i=1 into a FIFO entry of {cnt, last, data}, where last = (bot_i_cnt_i == latched last cnt).
REQ-019 The block SHALL present the FIFO head on st_* one cycle after the write, without passing the input through combinationally.
REQ-020 The block SHALL pop the head on any cycle with st_valid_o=1 and st_ready_i=1; st_valid_o=0 SHALL mean the FIFO is empty.
REQ-021 The block SHALL hold st_* stable while st_valid_o=1 and st_ready_i=0.
REQ-022 On a write to a full FIFO with no pop in the same cycle, the block SHALL drop the row and set overflow_o; on a write to a full FIFO with a pop in the same cycle, it SHALL accept the row.
REQ-023 The FIFO pointers SHALL wrap modulo DEPTH, and occupancy SHALL range 0..DEPTH.
REQ-024 The block SHALL keep an expected-row counter that is 0 at tile start and increments on each accepted write; a write with bot_i_cnt_i different from the counter SHALL set seq_err_o while the row is still stored.
REQ-025 The FSM SHALL have states IDLE, COLLECT, FLUSH and DONE, with these transitions:
- IDLE->COLLECT on the first write (latch cfg_last_cnt_i).
- COLLECT->FLUSH on acceptance of the last row.
- FLUSH->DONE on the pop of an entry with last=1.
- DONE->IDLE unconditionally after one cycle.
REQ-026 The block SHALL assert post_storec_valid_o only in DONE, exactly one cycle per tile.
REQ-027 In FLUSH and DONE the block SHALL accept further writes, with each write starting the expected counter of the next tile from 0.
REQ-028 When cfg_last_cnt_i is 0, the first row SHALL be last and the FSM SHALL go IDLE->FLUSH directly.

Reset
REQ-029 While rst=1, the block SHALL force st_valid_o, st_last_o, post_storec_valid_o, almost_full_o, overflow_o and seq_err_o to 0 and st_cnt_o to 0, empty the FIFO, clear the expected counter and set the FSM to IDLE.
REQ-030 Reset SHALL discard any in-flight rows, and the first post-reset write SHALL start a new tile.
REQ-031 The FIFO data array SHALL need no reset, and st_data_o SHALL be don't-care while st_valid_o=0.

Configuration
REQ-032 With SARRAY_DRAIN_RELU_EN defined, the block SHALL replace each signed 32-bit lane with a negative value by 0 on write, and SHALL leave other lanes unchanged.
REQ-033 Without SARRAY_DRAIN_RELU_EN, the block SHALL store data bit-exact.

Verification
REQ-034 The bench SHALL cover: last=3, write rows 0..3 with st_ready_i=1 -> st_valid_o on cycles 1..4, st_last_o on row 3, post_storec_valid_o one cycle after that pop.
REQ-035 The bench SHALL cover: st_ready_i=0, write 5 rows with DEPTH=4 -> almost_full_o after 3 rows, overflow_o=1 after the 5th, rows 0..3 drained intact.
REQ-036 The bench SHALL cover: full FIFO, simultaneous write and pop -> occupancy stays 4, overflow_o stays 0.
REQ-037 The bench SHALL cover: rows 0, 1 and 3 written -> seq_err_o=1 from the cycle after row 3, and row 3 is still output.
REQ-038 The bench SHALL cover: rst asserted with 2 rows queued -> all outputs 0 next cycle; new rows 0..3 complete a tile normally.
REQ-039 The bench SHALL cover: RELU_EN, lane0=0xFFFFFFFF and lane1=0x00000005 -> output lane0=0 and lane1=5; without the macro, lane0=0xFFFFFFFF.
